// File: rtl/pc_seq_unit_pkg.sv
// pc_pkg: op encoding and sign-extension helper shared by the PC sequencer files.
package pc_pkg;
  typedef enum logic [1:0] {
    PC_OP_SEQ  = 2'b00,
    PC_OP_JUMP = 2'b01,
    PC_OP_CALL = 2'b10,
    PC_OP_RET  = 2'b11
  } pc_op_e;
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] s;
    s = signed'(v << (64 - w));
    return s >>> (64 - w);
  endfunction
endpackage

// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control-side request signals and PC/stack status of the PC sequencer.
interface pc_seq_unit_if
  import pc_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int OFF_W = 12
);
  logic             updatePC;
  pc_op_e           op;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  PC;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;
  modport master(output updatePC, op, offset, input PC, ras_empty, ras_full, ras_err);
  modport slave(input updatePC, op, offset, output PC, ras_empty, ras_full, ras_err);
endinterface

// File: rtl/pc_seq_unit_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            Clk2,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [AW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;
  // ptr_q is the next free slot; when full that slot is the oldest entry
  assign top_idx   = ptr_q - AW'(1);
  assign top_data  = mem_q[top_idx];
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(RAS_DEPTH);
  assign do_pop    = pop && !push && !empty;
  assign overflow  = push && full;
  assign underflow = pop && !push && empty;
  always_comb begin
    ptr_d   = push ? ptr_q + AW'(1) : do_pop ? top_idx : ptr_q;
    count_d = push ? (full ? count_q : count_q + CW'(1)) : do_pop ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge Clk2) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (push) mem_q[ptr_q] <= push_data;
    end
  end
endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: PC register with sequential/relative/call/return update, one op per Clk2 edge.
// Macro PC_RAS_EN enables the return-address stack; without it CALL acts as JUMP and RET as SEQ.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              OFF_W     = 12,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input logic          Clk2,
  input logic          reset,
  pc_seq_unit_if.slave bus
);
  if (OFF_W > PC_W || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("pc_seq_unit: illegal OFF_W/RAS_DEPTH");
  end
  logic [PC_W-1:0] pc_q, pc_d, ext_off, seq_pc, rel_pc;
  assign ext_off = PC_W'(sext(64'(bus.offset), OFF_W));
  assign seq_pc  = pc_q + PC_W'(1);
  assign rel_pc  = pc_q + ext_off;
`ifdef PC_RAS_EN
  logic            push, pop, empty, full, ovf, unf, err_q, err_d;
  logic [PC_W-1:0] top;
  assign push = bus.updatePC && bus.op == PC_OP_CALL;
  assign pop  = bus.updatePC && bus.op == PC_OP_RET;
  pc_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .Clk2(Clk2), .reset(reset), .push(push), .pop(pop), .push_data(seq_pc),
    .top_data(top), .empty(empty), .full(full), .overflow(ovf), .underflow(unf)
  );
  always_comb begin
    pc_d  = !bus.updatePC ? pc_q : (bus.op == PC_OP_JUMP || push) ? rel_pc : (pop && !empty) ? top : seq_pc;
    err_d = err_q | ovf | unf;
  end
  always_ff @(posedge Clk2) err_q <= reset ? 1'b0 : err_d;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;
`else
  always_comb begin
    pc_d = !bus.updatePC ? pc_q : (bus.op == PC_OP_JUMP || bus.op == PC_OP_CALL) ? rel_pc : seq_pc;
  end
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif
  always_ff @(posedge Clk2) pc_q <= reset ? RESET_VEC : pc_d;
  assign bus.PC = pc_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: scoreboard bench for pc_seq_unit; expectations follow PC_RAS_EN.
module tb_pc_seq_unit;
  import pc_pkg::*;
  typedef logic [18:0] obs_t;
  logic Clk2 = 1'b0;
  logic reset = 1'b1;
  always #5 Clk2 = ~Clk2;
  pc_seq_unit_if #(.PC_W(16), .OFF_W(12)) bus();
  pc_seq_unit #(.PC_W(16), .OFF_W(12), .RAS_DEPTH(4), .RESET_VEC(16'h0010)) dut (
    .Clk2(Clk2), .reset(reset), .bus(bus)
  );
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_err;
  obs_t        sb[$];
  obs_t        got[$];
  int          n_run = 0;
  int          n_fail = 0;

  task automatic issue(input logic r, input logic u, input logic [1:0] o, input logic [11:0] off);
    logic [15:0] ext;
    @(negedge Clk2);
    reset = r;
    bus.updatePC = u;
    bus.op = pc_op_e'(o);
    bus.offset = off;
    ext = {{4{off[11]}}, off};
    if (r) begin
      m_pc = 16'h0010;
      m_stk.delete();
      m_err = 1'b0;
    end else if (u) begin
      if (o == 2'd0) m_pc = m_pc + 16'd1;
      else if (o == 2'd1) m_pc = m_pc + ext;
      else if (o == 2'd2) begin
`ifdef PC_RAS_EN
        if (m_stk.size() == 4) begin
          m_stk.delete(0);
          m_err = 1'b1;
        end
        m_stk.push_back(m_pc + 16'd1);
`endif
        m_pc = m_pc + ext;
      end else begin
`ifdef PC_RAS_EN
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc = m_pc + 16'd1;
          m_err = 1'b1;
        end
`else
        m_pc = m_pc + 16'd1;
`endif
      end
    end
    sb.push_back({m_pc, m_stk.size() == 0, m_stk.size() == 4, m_err});
    @(posedge Clk2);
    #1;
    got.push_back({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err});
  endtask

  task automatic goto_pc(input logic [15:0] t);
    logic [15:0] d;
    d = t - m_pc;
    issue(1'b0, 1'b1, 2'd1, d[11:0]);
  endtask

  task automatic test_reset();
    issue(1'b1, 1'b1, 2'd1, 12'h100);
    issue(1'b0, 1'b1, 2'd2, 12'h020);
    issue(1'b1, 1'b1, 2'd2, 12'h020);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  task automatic test_seq_wrap_hold();
    issue(1'b1, 1'b0, 2'd0, 12'h000);
    goto_pc(16'hFFFE);
    issue(1'b0, 1'b1, 2'd0, 12'h000);
    issue(1'b0, 1'b1, 2'd0, 12'h000);
    for (int k = 0; k < 3; k++) issue(1'b0, 1'b0, 2'($urandom_range(0, 3)), 12'($urandom));
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL seq_wrap_hold step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  task automatic test_jumps();
    goto_pc(16'h0100);
    issue(1'b0, 1'b1, 2'd1, 12'h0FF);
    issue(1'b0, 1'b1, 2'd1, 12'hF01);
    issue(1'b0, 1'b1, 2'd1, 12'h7FF);
    issue(1'b0, 1'b1, 2'd1, 12'h800);
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL jumps step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  task automatic test_call_ret();
    goto_pc(16'h0020);
    issue(1'b0, 1'b1, 2'd2, 12'h010);
    issue(1'b0, 1'b1, 2'd2, 12'h010);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL call_ret step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  task automatic test_overflow();
    goto_pc(16'h0000);
    for (int k = 0; k < 5; k++) issue(1'b0, 1'b1, 2'd2, 12'h001);
    for (int k = 0; k < 5; k++) issue(1'b0, 1'b1, 2'd3, 12'h000);
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL overflow step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  task automatic test_underflow();
    issue(1'b1, 1'b0, 2'd0, 12'h000);
    goto_pc(16'h0050);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    issue(1'b0, 1'b0, 2'd3, 12'h000);
    issue(1'b0, 1'b1, 2'd0, 12'h000);
    issue(1'b1, 1'b0, 2'd0, 12'h000);
    goto_pc(16'h0010);
    issue(1'b0, 1'b1, 2'd2, 12'h004);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL underflow step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 2'd0, 12'h000);
    issue(1'b0, 1'b1, 2'd2, 12'h100);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    issue(1'b0, 1'b1, 2'd2, 12'hF80);
    issue(1'b0, 1'b1, 2'd2, 12'h033);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    issue(1'b0, 1'b1, 2'd2, 12'h005);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    issue(1'b0, 1'b1, 2'd3, 12'h000);
    for (int k = 0; k < 80; k++)
      issue($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 12'($urandom));
    for (int i = 0; sb.size() > 0; i++) begin
      obs_t e = sb.pop_front();
      obs_t g = got.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b", i, g[18:3], g[2:0], e[18:3], e[2:0]);
      end
    end
  endtask

  initial begin
    bus.updatePC = 1'b0;
    bus.op = PC_OP_SEQ;
    bus.offset = '0;
    m_pc = 16'h0010;
    m_err = 1'b0;
    test_reset();
    test_seq_wrap_hold();
    test_jumps();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer; successor to the fixed 16-bit PC updater. Advances, branches relative, and performs call/return through an internal return-address stack (RAS), one operation per enabled `Clk2` edge. Sits between the control FSM (which asserts `updatePC` once per instruction) and instruction fetch, which consumes `PC`.

## Interface

**Parameters**
- `PC_W`, default 16: PC width.
- `OFF_W`, default 12: branch offset width; must satisfy `OFF_W <= PC_W`.
- `RAS_DEPTH`, default 4: number of return-stack entries; power of two, at least 2.
- `RESET_VEC`, default 0: PC value loaded on reset.

**Ports**
- `Clk2`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `updatePC`, in, 1: perform `op` on this edge.
- `op`, in, 2: operation select. 00 SEQ, 01 JUMP, 10 CALL, 11 RET.
- `offset`, in, `OFF_W`: signed two's-complement relative offset.
- `PC`, out, `PC_W`: current program counter, registered.
- `ras_empty`, out, 1: stack holds 0 entries, registered.
- `ras_full`, out, 1: stack holds `RAS_DEPTH` entries, registered.
- `ras_err`, out, 1: sticky flag for stack overflow or underflow; cleared only by reset.

## Operation

- `ext_off` is `offset` sign-extended to `PC_W`.
- All PC arithmetic is modulo 2^`PC_W`; wrap-around is silent (0xFFFF + 1 gives 0x0000 at `PC_W`=16).
- `updatePC`=0: PC, stack and flags hold; `op` and `offset` are ignored.
- `updatePC`=1:
  - SEQ: PC <= PC + 1.
  - JUMP: PC <= PC + `ext_off`.
  - CALL: push PC + 1; PC <= PC + `ext_off`.
    - Stack full: the push overwrites the oldest entry (circular), count stays `RAS_DEPTH`, and `ras_err` is set.
  - RET, stack non-empty: PC <= top entry; pop.
  - RET, stack empty: PC <= PC + 1; `ras_err` is set; stack is unchanged.
- Stack organisation: circular buffer with a top pointer and an occupancy count (0..`RAS_DEPTH`).
- Reset:
  - PC <= `RESET_VEC`, count <= 0, pointer <= 0, `ras_err` <= 0.
  - Hence `ras_empty`=1 and `ras_full`=0.
  - Reset takes priority over `updatePC` on the same edge and aborts any operation in flight; no push or pop is committed.

## Timing

- Latency is 1 cycle: the effect of an op sampled at edge N is visible on `PC` and the flags immediately after edge N.
- Throughput is one op per cycle. Back-to-back CALL/RET on consecutive edges must work, e.g. CALL then RET returns to the CALL address + 1.
- No combinational path from inputs to outputs; every output is a flop or a decode of flops.
- Stack memory is read combinationally from the top pointer and written on the edge. Same-edge pop-then-push cannot occur, since there is only one op per edge.

## Configuration

- Macro `PC_RAS_EN`.
- Defined: full behaviour as above, with `pc_ras` instantiated.
- Undefined:
  - No stack storage.
  - CALL behaves exactly as JUMP (no push).
  - RET behaves exactly as SEQ.
  - `ras_empty` is tied 1, `ras_full` tied 0, `ras_err` tied 0.
  - `RAS_DEPTH` is ignored.

## Structure

- Package `pc_pkg` holds:
  - The `op` encoding as a 2-bit enum: `PC_OP_SEQ`, `PC_OP_JUMP`, `PC_OP_CALL`, `PC_OP_RET`.
  - A sign-extension function parameterised by width.
- Sub-module `pc_ras` is the circular return stack.
  - Ports: clock, reset, push, pop, `push_data`, `top_data`, empty, full, overflow, underflow.
  - Parameters: `PC_W`, `RAS_DEPTH`.
- Top level: PC register, next-PC mux, sticky error flop.

## Test plan

1. **Reset.** Drive `reset`=1 with `updatePC`=1 and op=JUMP on the same edge, `RESET_VEC`=0x0010. Expect PC=0x0010, `ras_empty`=1, `ras_err`=0.
2. **SEQ wrap and hold.** From PC=0xFFFE, issue SEQ twice: expect 0xFFFF, then 0x0000. With `updatePC`=0 for 3 cycles, PC stays 0x0000.
3. **Relative jumps.** From PC=0x0100:
   - JUMP with offset 0x0FF (+255): expect PC=0x01FF.
   - Then JUMP with offset 0xF01 (-255): expect PC=0x0100.
4. **Call/return.** From PC=0x0020:
   - CALL offset 0x010: expect PC=0x0030.
   - CALL offset 0x010: expect PC=0x0040.
   - RET: expect PC=0x0031. RET again: expect PC=0x0021, `ras_empty`=1.
5. **Overflow.** With `RAS_DEPTH`=4, issue 5 CALLs with offset 1 starting at PC=0. Expect `ras_full`=1 and `ras_err`=1. Then 4 RETs return to 5, 4, 3, 2 in that order (the oldest entry was lost).
6. **Underflow and disabled build.**
   - RET on an empty stack at PC=0x0050: expect PC=0x0051 and `ras_err`=1.
   - Build without `PC_RAS_EN`: CALL offset 0x004 from 0x0010 gives 0x0014; RET gives 0x0015.
